// File: rtl/tx_sched_if.sv
// Host/serializer-facing signal bundle of the CDBUS TX scheduler.
// The master side drives the configuration and event pulses; the slave side is the scheduler.
interface tx_sched_if #(
   parameter int IDLE_W = 10
);
   logic [15:0]       period_ls;
   logic [IDLE_W-1:0] bus_idle_len;
   logic [IDLE_W-1:0] tx_wait_len;
   logic              rx_busy;
   logic              sw_commit;
   logic              tx_abort;
   logic              read_done;
   logic              cd;
   logic              cd_err;
   logic              sw_page;
   logic              tx_page;
   logic              unread;
   logic              tx_permit;
   logic [1:0]        pend_cnt;
   logic              tx_done;
   logic              tx_err;
   logic              commit_ovf;

   modport master (
      output period_ls, bus_idle_len, tx_wait_len, rx_busy, sw_commit, tx_abort,
             read_done, cd, cd_err,
      input  sw_page, tx_page, unread, tx_permit, pend_cnt, tx_done, tx_err, commit_ovf
   );

   modport slave (
      input  period_ls, bus_idle_len, tx_wait_len, rx_busy, sw_commit, tx_abort,
             read_done, cd, cd_err,
      output sw_page, tx_page, unread, tx_permit, pend_cnt, tx_done, tx_err, commit_ovf
   );
endinterface

// File: rtl/tx_sched.sv
// CDBUS TX scheduler: two-page buffer ownership, idle-gap gated tx_permit; TX_BACKOFF_EN stretches the gap per retry.
// All outputs registered one cycle after their cause; no backpressure, overflowing commits are flagged.
module tx_sched #(
   parameter int IDLE_W = 10
) (
   input  logic       clk,
   input  logic       reset_n,
   tx_sched_if.slave  bus
);
   // Wide enough that idle + wait + (wait << 3) can never wrap.
   localparam int THR_W = IDLE_W + 4;

   typedef enum logic [3:0] {
      S_IDLE   = 4'b0001,
      S_COUNT  = 4'b0010,
      S_PERMIT = 4'b0100,
      S_TX     = 4'b1000
   } state_t;

   state_t            state, state_nxt;
   logic [15:0]       pcnt;
   logic [IDLE_W-1:0] icnt;
   logic [1:0]        pend, pend_nxt;
   logic [1:0]        retry;
   logic              sw_page, sw_page_nxt;
   logic              tx_page, tx_page_nxt;
   logic              unread, tx_permit, tx_done, tx_err, commit_ovf;
   logic [1:0]        pend_cnt;
   logic [THR_W-1:0]  boff, thr;
   logic              tick, idle_met, abort_ok, commit_ok;

   assign tick     = !bus.rx_busy && (pcnt == bus.period_ls);
   assign abort_ok = bus.tx_abort && (state == S_IDLE || state == S_COUNT);
   assign commit_ok = bus.sw_commit && !pend[sw_page] && !abort_ok;

`ifdef TX_BACKOFF_EN
   assign boff = THR_W'(bus.tx_wait_len) << retry;
`else
   assign boff = '0;
`endif

   assign thr      = THR_W'(bus.bus_idle_len) + THR_W'(bus.tx_wait_len) + boff;
   assign idle_met = THR_W'(icnt) >= thr;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pcnt <= '0;
         icnt <= '0;
      end else if (bus.rx_busy) begin
         pcnt <= '0;
         icnt <= '0;
      end else if (tick) begin
         pcnt <= '0;
         if (icnt != '1) icnt <= icnt + 1'b1;
      end else begin
         pcnt <= pcnt + 16'd1;
      end
   end

   always_comb begin
      pend_nxt    = pend;
      sw_page_nxt = sw_page;
      tx_page_nxt = tx_page;
      if (abort_ok) begin
         pend_nxt    = '0;
         tx_page_nxt = sw_page;
      end else begin
         if (bus.read_done) begin
            pend_nxt[tx_page] = 1'b0;
            tx_page_nxt       = ~tx_page;
         end
         if (commit_ok) begin
            pend_nxt[sw_page] = 1'b1;
            sw_page_nxt       = ~sw_page;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (pend != 2'b00 && !abort_ok) state_nxt = S_COUNT;
         S_COUNT:  if (abort_ok || pend == 2'b00) state_nxt = S_IDLE;
                   else if (idle_met && !bus.rx_busy && unread) state_nxt = S_PERMIT;
         S_PERMIT: if (bus.cd) state_nxt = S_COUNT;
                   else if (bus.rx_busy) state_nxt = S_TX;
         S_TX:     if (bus.read_done) state_nxt = (pend_nxt != 2'b00) ? S_COUNT : S_IDLE;
                   else if (bus.cd) state_nxt = S_COUNT;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         pend       <= '0;
         sw_page    <= 1'b0;
         tx_page    <= 1'b0;
         retry      <= '0;
         unread     <= 1'b0;
         tx_permit  <= 1'b0;
         pend_cnt   <= '0;
         tx_done    <= 1'b0;
         tx_err     <= 1'b0;
         commit_ovf <= 1'b0;
      end else begin
         state      <= state_nxt;
         pend       <= pend_nxt;
         sw_page    <= sw_page_nxt;
         tx_page    <= tx_page_nxt;
         unread     <= pend_nxt[tx_page_nxt];
         tx_permit  <= (state_nxt == S_PERMIT);
         pend_cnt   <= {1'b0, pend_nxt[0]} + {1'b0, pend_nxt[1]};
         tx_done    <= bus.read_done && !bus.cd_err;
         tx_err     <= bus.read_done && bus.cd_err;
         commit_ovf <= bus.sw_commit && pend[sw_page] && !abort_ok;
         if (bus.read_done || abort_ok) retry <= '0;
         else if (state == S_TX && bus.cd) retry <= retry + 2'd1;
      end
   end

   assign bus.sw_page    = sw_page;
   assign bus.tx_page    = tx_page;
   assign bus.unread     = unread;
   assign bus.tx_permit  = tx_permit;
   assign bus.pend_cnt   = pend_cnt;
   assign bus.tx_done    = tx_done;
   assign bus.tx_err     = tx_err;
   assign bus.commit_ovf = commit_ovf;
endmodule
